// File: rtl/helen_sample_logger.sv
// Streams 32-bit samples into a circular word buffer in on-chip RAM through an
// Avalon-MM write master, with one pending slot and a saturating drop counter.
module helen_sample_logger #(
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 4096,
  parameter int BASE_WORD = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [31:0]       sample_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic              pend_valid;
  logic [31:0]       pend_data;
  logic              clr_hold;
  logic              accept;
  logic              take;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] next_ptr;

  assign accept   = (state == WRITE) && !avm_waitrequest;
  assign take     = enable && sample_valid && !clear;
  assign ptr_inc  = (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + ADDR_W'(1);
  // A write that was in flight when clear arrived does not consume a ring slot.
  assign next_ptr = clr_hold ? wr_ptr : ptr_inc;

  assign avm_byteenable = 4'hF;
  assign busy           = (state == WRITE) | pend_valid;

  // The address is registered so it can stay put while clear zeroes wr_ptr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pend_valid     <= 1'b0;
      pend_data      <= '0;
      clr_hold       <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_address    <= BASE_ADDR;
      wr_ptr         <= '0;
      wrapped        <= 1'b0;
      drop_cnt       <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      wrapped    <= 1'b0;
      drop_cnt   <= '0;
      pend_valid <= 1'b0;
      if (state == WRITE && !accept) begin
        clr_hold <= 1'b1;
      end else begin
        state          <= IDLE;
        avm_chipselect <= 1'b0;
        avm_write      <= 1'b0;
        clr_hold       <= 1'b0;
        avm_address    <= BASE_ADDR;
      end
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state          <= WRITE;
            avm_chipselect <= 1'b1;
            avm_write      <= 1'b1;
            avm_writedata  <= sample_data;
            avm_address    <= BASE_ADDR + wr_ptr;
          end
        end
        WRITE: begin
          if (accept) begin
            if (!clr_hold) begin
              wr_ptr <= ptr_inc;
              if (wr_ptr == LAST_SLOT) wrapped <= 1'b1;
            end
            clr_hold    <= 1'b0;
            avm_address <= BASE_ADDR + next_ptr;
            if (pend_valid) begin
              avm_writedata <= pend_data;
              pend_valid    <= take;
              if (take) pend_data <= sample_data;
            end else if (take) begin
              avm_writedata <= sample_data;
            end else begin
              state          <= IDLE;
              avm_chipselect <= 1'b0;
              avm_write      <= 1'b0;
            end
          end else if (take) begin
            if (!pend_valid) begin
              pend_valid <= 1'b1;
              pend_data  <= sample_data;
            end else if (drop_cnt != 16'hFFFF) begin
              drop_cnt <= drop_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
